rf_port_arbiter: RTL
====================

// Module: rf_port_arbiter
// PURPOSE
//   Shares the general-register-file write port between the ex writeback path and the
//   debug (jtag) requester, and serves debug register reads on the regfile's jtag read port.
//   Ex writes always win; a blocked debug write waits, and after STARVE_MAX lost cycles
//   the block stalls the pipeline via hold_o to force the debug write in.
// PARAMETERS
//   STARVE_MAX  8   ex-busy cycles a pending debug write tolerates before hold_o is raised (1..255)
//   CNT_W       8   width of the starvation counter
// PORTS
//   clk          in   1   clock
//   rst          in   1   reset; synchronous, active-high
//   ex_we_i      in   1   ex writeback enable
//   ex_waddr_i   in   5   ex writeback address
//   ex_wdata_i   in   32  ex writeback data
//   dbg_req_i    in   1   debug request; held high until dbg_ack_o
//   dbg_we_i     in   1   1 = write, 0 = read; stable while dbg_req_i high
//   dbg_addr_i   in   5   debug register address; stable while dbg_req_i high
//   dbg_wdata_i  in   32  debug write data; stable while dbg_req_i high
//   dbg_ack_o    out  1   one-cycle completion pulse
//   dbg_rdata_o  out  32  read data, valid in the dbg_ack_o cycle and held until next ack
//   dbg_busy_o   out  1   state != IDLE
//   hold_o       out  1   pipeline stall request (registered)
//   rf_we_o      out  1   regfile write enable
//   rf_waddr_o   out  5   regfile write address
//   rf_wdata_o   out  32  regfile write data
//   rf_raddr_o   out  5   regfile jtag read address (= dbg_addr_i)
//   rf_rdata_i   in   32  regfile jtag read data (combinational, x0 reads 0)
// BEHAVIOUR
//   - Reset: state IDLE, starve_cnt 0, dbg_ack_o 0, dbg_rdata_o 0, hold_o 0. A request in
//     flight at reset is dropped without ack; requester re-issues after rst falls.
//   - Write-port mux (combinational): if ex_we_i -> rf_* = ex_*; else if dbg_grant ->
//     rf_we_o=1, rf_waddr_o=dbg_addr_i, rf_wdata_o=dbg_wdata_i; else rf_we_o=0.
//     dbg_grant = dbg write pending in IDLE/WAIT/HOLD and ex_we_i==0. Ex is never dropped.
//   - FSM states: IDLE, WAIT, HOLD, RESP.
//     IDLE: dbg_req_i&!dbg_we_i -> capture rf_rdata_i into dbg_rdata_o, -> RESP.
//           dbg_req_i&dbg_we_i&!ex_we_i -> write issued this cycle, -> RESP.
//           dbg_req_i&dbg_we_i&ex_we_i -> -> WAIT, starve_cnt=1.
//     WAIT: !ex_we_i -> write issued, -> RESP, cnt=0. Else cnt++; when cnt reaches
//           STARVE_MAX -> HOLD, hold_o<=1.
//     HOLD: hold_o=1. !ex_we_i -> write issued, -> RESP, hold_o<=0, cnt=0.
//           ex_we_i still high (in-flight write) -> stay HOLD, ex wins.
//     RESP: dbg_ack_o=1 (registered pulse), hold_o=0; unconditionally -> IDLE.
//   - Latency: read or uncontended write = ack 1 cycle after request accepted in IDLE.
//     Worst case write with continuous ex traffic = STARVE_MAX + 1 + in-flight ex cycles + 1.
//   - dbg_req_i is not sampled in RESP; next request accepted earliest the cycle after ack.
//   - Debug write to x0: issued and acked normally; regfile discards it.
//   - Debug read sees the regfile array, not a same-cycle ex write (no bypass on jtag port).
//   - dbg_req_i dropping before ack is a protocol violation; behaviour undefined.
//   - Counter saturates at STARVE_MAX, never wraps.
// TESTING
//   1 Reset: hold rst 2 cycles mid-WAIT -> state IDLE, hold_o=0, no ack, rf_we_o=ex_we_i.
//   2 Debug read x5=0x1234_5678, ex idle -> ack 1 cycle after req, dbg_rdata_o=0x12345678.
//   3 Debug write x7=0xDEAD_BEEF, ex idle -> rf_we_o=1,waddr=7 same cycle, ack next cycle.
//   4 Debug write while ex writes x3 for 3 cycles -> ex writes all land, debug write in
//     cycle 4, ack cycle 5, hold_o never asserted (STARVE_MAX=8).
//   5 Debug write with ex_we_i held high 20 cycles -> hold_o rises after 8 lost cycles;
//     bench drops ex_we_i 1 cycle later -> debug write issued, ack, hold_o=0.
//   6 Simultaneous ex write x9=0x1 and debug write x9=0x2 -> x9 ends 0x2, ex write not lost;
//     back-to-back reqs -> second accepted only the cycle after first ack.

Source files
------------

// File: rtl/rf_port_arbiter_if.sv
// rf_port_arbiter_if: ex writeback, debug request and regfile port signals of the arbiter
interface rf_port_arbiter_if;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_rdata_o;
  logic        dbg_busy_o;
  logic        hold_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  rf_raddr_o;
  logic [31:0] rf_rdata_i;
  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, rf_rdata_i,
    output dbg_ack_o, dbg_rdata_o, dbg_busy_o, hold_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_raddr_o
  );
  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i, dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, rf_rdata_i,
    input  dbg_ack_o, dbg_rdata_o, dbg_busy_o, hold_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_raddr_o
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares the regfile write port between ex writeback and debug, with starvation hold
module rf_port_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 8
) (
  input logic              clk,
  input logic              rst,
  rf_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             hold_q, hold_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             grant;
  assign grant = bus.dbg_req_i & bus.dbg_we_i & (state_q != RESP) & ~bus.ex_we_i;
  assign bus.rf_we_o     = bus.ex_we_i | grant;
  assign bus.rf_waddr_o  = bus.ex_we_i ? bus.ex_waddr_i : bus.dbg_addr_i;
  assign bus.rf_wdata_o  = bus.ex_we_i ? bus.ex_wdata_i : bus.dbg_wdata_i;
  assign bus.rf_raddr_o  = bus.dbg_addr_i;
  assign bus.dbg_ack_o   = state_q == RESP;
  assign bus.dbg_busy_o  = state_q != IDLE;
  assign bus.hold_o      = hold_q;
  assign bus.dbg_rdata_o = rdata_q;
  assign cnt_inc = (cnt_q >= MAX) ? cnt_q : cnt_q + CNT_W'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.dbg_req_i) begin
        if (!bus.dbg_we_i) begin
          rdata_d = bus.rf_rdata_i;
          state_d = RESP;
        end else if (!bus.ex_we_i) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = (MAX <= CNT_W'(1)) ? HOLD : WAIT;
          hold_d  = MAX <= CNT_W'(1);
        end
      end
      WAIT: if (!bus.ex_we_i) begin
        state_d = RESP;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc >= MAX) ? HOLD : WAIT;
        hold_d  = cnt_inc >= MAX;
      end
      // an ex write already in flight still wins while the pipeline drains
      HOLD: if (!bus.ex_we_i) begin
        state_d = RESP;
        hold_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        hold_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
